dbc_port_fsm_multi: RTL and testbench

//  Parametrised DbC port state machine for NUM_PORTS independent debug ports.
//  - Tracks connect, bus reset, enable, link and config-error events for each port.
//  - Latches the xHCI-style change bits (CSC, PRC, PLC, CEC); software clears them write-1-to-clear.
//  - Raises one aggregated event interrupt.
//  - Sits between the per-port PHY/link status logic and the DbC register block.

---
 rtl/dbc_port_fsm_multi_pkg.sv | 28 ++
 rtl/dbc_port_fsm_core.sv | 130 +++++++++++++
 rtl/dbc_port_fsm_multi.sv | 61 ++++++
 tb/tb_dbc_port_fsm_multi.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbc_port_fsm_multi_pkg.sv
// Shared definitions for the DbC multi-port state machine: state encodings and change-bit layout.
// Used by dbc_port_fsm_core and dbc_port_fsm_multi (optional feature macro: DBC_DEBOUNCE_EN).
package dbc_port_fsm_multi_pkg;

    localparam int STATE_W = 3;
    localparam int CHG_W   = 4;

    localparam int CHG_CSC = 0;
    localparam int CHG_PRC = 1;
    localparam int CHG_PLC = 2;
    localparam int CHG_CEC = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_DISABLED     = 3'd0,
        ST_DISCONNECTED = 3'd1,
        ST_DEBOUNCE     = 3'd2,
        ST_CONNECTED    = 3'd3,
        ST_RESETTING    = 3'd4,
        ST_ENABLED      = 3'd5,
        ST_ERROR        = 3'd6
    } port_state_e;

    // A device is physically attached (ccs=1) in exactly these states.
    function automatic logic is_attached(input port_state_e s);
        return s inside {ST_CONNECTED, ST_RESETTING, ST_ENABLED, ST_ERROR};
    endfunction

endpackage

// File: rtl/dbc_port_fsm_core.sv
// One DbC port: state machine, connect debounce counter, ccs/ped and the RW1C change bits.
// The debounce state and counter exist only when DBC_DEBOUNCE_EN is defined.
module dbc_port_fsm_core
    import dbc_port_fsm_multi_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               dce_i,
    input  logic               connect_i,
    input  logic               bus_reset_i,
    input  logic               link_chg_i,
    input  logic               cfg_err_i,
    input  logic [CHG_W-1:0]   clr_chg_i,
    output logic [STATE_W-1:0] port_state_o,
    output logic               ccs_o,
    output logic               ped_o,
    output logic [CHG_W-1:0]   chg_o
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    port_state_e      state_q, state_d;
    logic             ccs_q, ccs_d;
    logic             ped_q, ped_d;
    logic [CHG_W-1:0] chg_q, chg_d;
    logic [CHG_W-1:0] chg_set;

`ifdef DBC_DEBOUNCE_EN
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_DISABLED;
            ccs_q   <= 1'b0;
            ped_q   <= 1'b0;
            chg_q   <= '0;
`ifdef DBC_DEBOUNCE_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ccs_q   <= ccs_d;
            ped_q   <= ped_d;
            chg_q   <= chg_d;
`ifdef DBC_DEBOUNCE_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
`ifdef DBC_DEBOUNCE_EN
        cnt_d   = cnt_q;
`endif
        if (!dce_i) begin
            state_d = ST_DISABLED;
`ifdef DBC_DEBOUNCE_EN
            cnt_d   = '0;
`endif
        end else if (!connect_i && (state_q == ST_DEBOUNCE || is_attached(state_q))) begin
            state_d = ST_DISCONNECTED;
        end else if (cfg_err_i && state_q == ST_ENABLED) begin
            state_d = ST_ERROR;
        end else if (bus_reset_i && state_q inside {ST_CONNECTED, ST_ENABLED, ST_ERROR}) begin
            state_d = ST_RESETTING;
        end else begin
            case (state_q)
                ST_DISABLED: state_d = ST_DISCONNECTED;
                ST_DISCONNECTED: begin
                    if (connect_i) begin
`ifdef DBC_DEBOUNCE_EN
                        state_d = ST_DEBOUNCE;
                        cnt_d   = '0;
`else
                        state_d = ST_CONNECTED;
`endif
                    end
                end
`ifdef DBC_DEBOUNCE_EN
                // Only reached with connect high; a drop was handled above.
                ST_DEBOUNCE: begin
                    if (cnt_q >= CNT_LAST) begin
                        state_d = ST_CONNECTED;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif
                ST_RESETTING: begin
                    if (!bus_reset_i) begin
                        state_d = ST_ENABLED;
                    end
                end
                ST_CONNECTED, ST_ENABLED, ST_ERROR: state_d = state_q;
                default: state_d = ST_DISABLED;
            endcase
        end
    end

    // Change bits are derived from the chosen transition, so priority is decided in one place.
    always_comb begin
        chg_set          = '0;
        chg_set[CHG_CSC] = (state_q inside {ST_DISCONNECTED, ST_DEBOUNCE} && state_d == ST_CONNECTED)
                           || (ccs_q && state_d == ST_DISCONNECTED);
        chg_set[CHG_PRC] = state_q == ST_RESETTING && state_d == ST_ENABLED;
        chg_set[CHG_PLC] = link_chg_i && state_q == ST_ENABLED && state_d == ST_ENABLED;
        chg_set[CHG_CEC] = state_q == ST_ENABLED && state_d == ST_ERROR;

        ccs_d = is_attached(state_d);
        ped_d = state_d == ST_ENABLED;
        chg_d = dce_i ? ((chg_q & ~clr_chg_i) | chg_set) : '0;
    end

    assign port_state_o = state_q;
    assign ccs_o        = ccs_q;
    assign ped_o        = ped_q;
    assign chg_o        = chg_q;

endmodule

// File: rtl/dbc_port_fsm_multi.sv
// DbC port block: NUM_PORTS independent port FSMs plus the registered event interrupt.
// Define DBC_DEBOUNCE_EN to insert the connect debounce stage in every port.
module dbc_port_fsm_multi
    import dbc_port_fsm_multi_pkg::*;
#(
    parameter int NUM_PORTS       = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         dce,
    input  logic [NUM_PORTS-1:0]         connect,
    input  logic [NUM_PORTS-1:0]         bus_reset,
    input  logic [NUM_PORTS-1:0]         link_chg,
    input  logic [NUM_PORTS-1:0]         cfg_err,
    input  logic [CHG_W*NUM_PORTS-1:0]   clr_chg,
    input  logic                         irq_en,
    output logic [STATE_W*NUM_PORTS-1:0] port_state,
    output logic [NUM_PORTS-1:0]         ccs,
    output logic [NUM_PORTS-1:0]         ped,
    output logic [CHG_W*NUM_PORTS-1:0]   chg,
    output logic                         evt_irq
);

    if (NUM_PORTS < 1) begin : g_bad_ports
        $error("NUM_PORTS must be at least 1");
    end

    logic evt_irq_q;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        dbc_port_fsm_core #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_core (
            .clk         (clock),
            .rst_n       (reset_n),
            .dce_i       (dce),
            .connect_i   (connect[p]),
            .bus_reset_i (bus_reset[p]),
            .link_chg_i  (link_chg[p]),
            .cfg_err_i   (cfg_err[p]),
            .clr_chg_i   (clr_chg[p*CHG_W +: CHG_W]),
            .port_state_o(port_state[p*STATE_W +: STATE_W]),
            .ccs_o       (ccs[p]),
            .ped_o       (ped[p]),
            .chg_o       (chg[p*CHG_W +: CHG_W])
        );
    end

    // Masking happens before the flop, so the latched change bits are never touched by irq_en.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            evt_irq_q <= 1'b0;
        end else begin
            evt_irq_q <= irq_en & (|chg);
        end
    end

    assign evt_irq = evt_irq_q;

endmodule

// File: tb/tb_dbc_port_fsm_multi.sv
// Directed self-checking bench for dbc_port_fsm_multi (2 ports, 16-cycle debounce).
// Expectations adapt to whether DBC_DEBOUNCE_EN is defined for the build.
module tb_dbc_port_fsm_multi;

    localparam int NUM_PORTS       = 2;
    localparam int DEBOUNCE_CYCLES = 16;

    logic       clock;
    logic       reset_n;
    logic       dce;
    logic [1:0] connect;
    logic [1:0] bus_reset;
    logic [1:0] link_chg;
    logic [1:0] cfg_err;
    logic [7:0] clr_chg;
    logic       irq_en;
    logic [5:0] port_state;
    logic [1:0] ccs;
    logic [1:0] ped;
    logic [7:0] chg;
    logic       evt_irq;

    dbc_port_fsm_multi #(
        .NUM_PORTS      (NUM_PORTS),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .dce       (dce),
        .connect   (connect),
        .bus_reset (bus_reset),
        .link_chg  (link_chg),
        .cfg_err   (cfg_err),
        .clr_chg   (clr_chg),
        .irq_en    (irq_en),
        .port_state(port_state),
        .ccs       (ccs),
        .ped       (ped),
        .chg       (chg),
        .evt_irq   (evt_irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string      tag;
        logic [5:0] st;
        logic [1:0] ccs;
        logic [1:0] ped;
        logic [7:0] chg;
        logic       irq;
    } exp_t;

    exp_t       sb_q[$];
    logic [2:0] e_st[2];
    logic [1:0] e_ccs;
    logic [1:0] e_ped;
    logic [7:0] e_chg;
    logic [7:0] last_chg;
    int         checks = 0;
    int         errors = 0;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic sb_push(input string tag, input logic irq_exp);
        exp_t e;
        e.tag = tag;
        e.st  = {e_st[1], e_st[0]};
        e.ccs = e_ccs;
        e.ped = e_ped;
        e.chg = e_chg;
        e.irq = irq_exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        e = sb_q.pop_front();
        checks++;
        assert (port_state === e.st) else begin
            errors++;
            $error("FAIL %s port_state observed=%h expected=%h", e.tag, port_state, e.st);
        end
        checks++;
        assert (ccs === e.ccs) else begin
            errors++;
            $error("FAIL %s ccs observed=%b expected=%b", e.tag, ccs, e.ccs);
        end
        checks++;
        assert (ped === e.ped) else begin
            errors++;
            $error("FAIL %s ped observed=%b expected=%b", e.tag, ped, e.ped);
        end
        checks++;
        assert (chg === e.chg) else begin
            errors++;
            $error("FAIL %s chg observed=%h expected=%h", e.tag, chg, e.chg);
        end
        checks++;
        assert (evt_irq === e.irq) else begin
            errors++;
            $error("FAIL %s evt_irq observed=%b expected=%b", e.tag, evt_irq, e.irq);
        end
    endtask

    // One clock edge: queue the expected post-edge view, clock, then compare.
    task automatic cyc(input string tag);
        sb_push(tag, irq_en & (|last_chg));
        last_chg = e_chg;
        step();
        sb_check();
    endtask

    task automatic attach(input int p, input bit clear_csc, input string tag);
        connect[p] = 1'b1;
`ifdef DBC_DEBOUNCE_EN
        e_st[p] = 3'd2;
        cyc({tag, "_deb_enter"});
        repeat (DEBOUNCE_CYCLES - 1) cyc({tag, "_deb_hold"});
`endif
        e_st[p]       = 3'd3;
        e_ccs[p]      = 1'b1;
        e_chg[4*p]    = 1'b1;
        cyc({tag, "_connected"});
        if (clear_csc) begin
            clr_chg[4*p] = 1'b1;
            e_chg[4*p]   = 1'b0;
            cyc({tag, "_csc_clr"});
            clr_chg = '0;
        end
    endtask

    task automatic async_reset_check(input string tag);
        reset_n = 1'b0;
        #2;
        e_st[0]  = 3'd0;
        e_st[1]  = 3'd0;
        e_ccs    = '0;
        e_ped    = '0;
        e_chg    = '0;
        sb_push(tag, 1'b0);
        last_chg = '0;
        sb_check();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n   = 1'b0;
        dce       = 1'b0;
        connect   = '0;
        bus_reset = '0;
        link_chg  = '0;
        cfg_err   = '0;
        clr_chg   = '0;
        irq_en    = 1'b1;
        e_st[0]   = 3'd0;
        e_st[1]   = 3'd0;
        e_ccs     = '0;
        e_ped     = '0;
        e_chg     = '0;
        last_chg  = '0;
        step();
        cyc("reset");

        // Scenario 1: leave reset and enable DbC.
        reset_n = 1'b1;
        dce     = 1'b1;
        e_st[0] = 3'd1;
        e_st[1] = 3'd1;
        cyc("s1_dce_on");
        cyc("s1_idle");

        // Scenario 2: attach port 0, then clear CSC.
        attach(0, 1'b1, "s2");
        cyc("s2_irq_drop");

        // Disconnect from CONNECTED latches CSC.
        connect[0] = 1'b0;
        e_st[0]    = 3'd1;
        e_ccs[0]   = 1'b0;
        e_chg[0]   = 1'b1;
        cyc("dis_csc");
        clr_chg[0] = 1'b1;
        e_chg[0]   = 1'b0;
        cyc("dis_csc_clr");
        clr_chg = '0;

`ifdef DBC_DEBOUNCE_EN
        // Scenario 3: connect drops after 10 debounce cycles.
        connect[0] = 1'b1;
        e_st[0]    = 3'd2;
        cyc("s3_deb_enter");
        repeat (9) cyc("s3_deb_hold");
        connect[0] = 1'b0;
        e_st[0]    = 3'd1;
        cyc("s3_abort");
        cyc("s3_no_irq");
`endif

        // Scenario 4: bus reset, port 1 disconnected ignores its bus_reset.
        attach(0, 1'b1, "s4pre");
        bus_reset = 2'b11;
        e_st[0]   = 3'd4;
        repeat (5) cyc("s4_resetting");
        bus_reset = 2'b00;
        e_st[0]   = 3'd5;
        e_ped[0]  = 1'b1;
        e_chg[1]  = 1'b1;
        cyc("s4_enabled");
        clr_chg  = 8'h03;
        e_chg[1] = 1'b0;
        cyc("s4_prc_clr");
        clr_chg = '0;

        // Link change in ENABLED, irq masking keeps chg.
        link_chg = 2'b11;
        e_chg[2] = 1'b1;
        cyc("plc_set");
        link_chg = 2'b00;
        irq_en   = 1'b0;
        cyc("irq_masked");
        irq_en     = 1'b1;
        clr_chg[2] = 1'b1;
        e_chg[2]   = 1'b0;
        cyc("plc_clr");
        clr_chg = '0;

        // Scenario 5: cfg_err with same-cycle clear, set wins.
        cfg_err[0] = 1'b1;
        clr_chg[3] = 1'b1;
        e_st[0]    = 3'd6;
        e_ped[0]   = 1'b0;
        e_chg[3]   = 1'b1;
        cyc("s5_set_wins");
        cfg_err     = '0;
        clr_chg     = '0;
        link_chg[0] = 1'b1;
        cyc("s5_err_hold");
        link_chg   = '0;
        clr_chg[3] = 1'b1;
        e_chg[3]   = 1'b0;
        cyc("s5_cec_clr");
        clr_chg = '0;

        // ERROR exits through bus reset.
        bus_reset[0] = 1'b1;
        e_st[0]      = 3'd4;
        cyc("err_to_rst");
        bus_reset[0] = 1'b0;
        e_st[0]      = 3'd5;
        e_ped[0]     = 1'b1;
        e_chg[1]     = 1'b1;
        cyc("rst_to_en");

        // cfg_err outranks bus_reset and link_chg in the same cycle.
        cfg_err[0]   = 1'b1;
        bus_reset[0] = 1'b1;
        link_chg[0]  = 1'b1;
        e_st[0]      = 3'd6;
        e_ped[0]     = 1'b0;
        e_chg[3]     = 1'b1;
        cyc("prio_cfg");
        cfg_err  = '0;
        link_chg = '0;
        e_st[0]  = 3'd4;
        cyc("err_busrst");
        bus_reset = '0;
        e_st[0]   = 3'd5;
        e_ped[0]  = 1'b1;
        cyc("rst_done");

        // Port 1 activity alongside port 0.
        attach(1, 1'b0, "p1");
        clr_chg   = 8'h02;
        bus_reset = 2'b10;
        e_st[1]   = 3'd4;
        e_chg[1]  = 1'b0;
        cyc("indep_a");
        clr_chg   = '0;
        bus_reset = '0;
        e_st[1]   = 3'd5;
        e_ped[1]  = 1'b1;
        e_chg[5]  = 1'b1;
        cyc("indep_b");
        link_chg = 2'b11;
        cfg_err  = 2'b10;
        e_st[1]  = 3'd6;
        e_ped[1] = 1'b0;
        e_chg[7] = 1'b1;
        e_chg[2] = 1'b1;
        cyc("indep_c");
        link_chg = '0;
        cfg_err  = '0;

        // Scenario 6: build port 0 up to ENABLED with all four change bits set.
        connect[0] = 1'b0;
        e_st[0]    = 3'd1;
        e_ccs[0]   = 1'b0;
        e_ped[0]   = 1'b0;
        e_chg[0]   = 1'b1;
        cyc("s6_dis");
        attach(0, 1'b0, "s6");
        bus_reset[0] = 1'b1;
        e_st[0]      = 3'd4;
        cyc("s6_rst");
        bus_reset[0] = 1'b0;
        e_st[0]      = 3'd5;
        e_ped[0]     = 1'b1;
        e_chg[1]     = 1'b1;
        cyc("s6_all_set");
        dce     = 1'b0;
        e_st[0] = 3'd0;
        e_st[1] = 3'd0;
        e_ccs   = '0;
        e_ped   = '0;
        e_chg   = '0;
        cyc("s6_dce_off");
        cyc("s6_irq_off");

        // Re-enable with both connects high, then reset mid-operation.
        dce     = 1'b1;
        e_st[0] = 3'd1;
        e_st[1] = 3'd1;
        cyc("dce_on");
`ifdef DBC_DEBOUNCE_EN
        e_st[0] = 3'd2;
        e_st[1] = 3'd2;
`else
        e_st[0] = 3'd3;
        e_st[1] = 3'd3;
        e_ccs   = 2'b11;
        e_chg   = 8'h11;
`endif
        cyc("both_attach");
        async_reset_check("async_reset");
        reset_n = 1'b1;
        connect = '0;
        e_st[0] = 3'd1;
        e_st[1] = 3'd1;
        cyc("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
